alu_md_controller: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle ALU control decoder in the RISC-V core. Decodes ALUOp/Funct3/Funct7 into a 5-bit ALU operation code with zero latency, as today. It also adds an iterative RV32M multiply/divide sequencer that latches operands, stalls the pipeline while it iterates, and returns an XLEN-bit result with a one-cycle valid pulse. It sits in the execute stage between the main Controller, the register-file read ports and the ALU result mux.

---
 rtl/alu_md_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_md_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_controller.sv
// alu_md_controller
//   Execute-stage ALU control decoder with an iterative RV32M multiply/divide
//   sequencer. The ALU operation code is decoded with zero latency. M-type
//   instructions are latched into a shift-add multiplier or a restoring divider
//   that runs for XLEN cycles while holding the pipeline. The result is then
//   presented together with a one-cycle valid pulse.
//
// Parameters
//   XLEN      operand/result width (>= 8, even)
//   ENABLE_M  1 = M-ops execute, 0 = M-ops decode as ILLEGAL and never stall
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   valid_i                 instruction present in execute
//   ALUOp, IsRType          main-controller class of instruction
//   Funct7, Funct3          instruction function fields
//   rs1_i, rs2_i            M-op operands A and B
//   Operation               5-bit ALU operation code (combinational)
//   stall_o                 freeze PC/IF/ID/EX (combinational)
//   busy_o                  sequencer not idle (registered)
//   md_valid_o, md_result_o M-op result and its one-cycle valid pulse
module alu_md_controller #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp,
  input  logic            IsRType,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [4:0]      Operation,
  output logic            stall_o,
  output logic            busy_o,
  output logic            md_valid_o,
  output logic [XLEN-1:0] md_result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [4:0] OP_ADD     = 5'b00000;
  localparam logic [4:0] OP_SUB     = 5'b00001;
  localparam logic [4:0] OP_SLL     = 5'b00010;
  localparam logic [4:0] OP_SLT     = 5'b00011;
  localparam logic [4:0] OP_SLTU    = 5'b00100;
  localparam logic [4:0] OP_XOR     = 5'b00101;
  localparam logic [4:0] OP_SRL     = 5'b00110;
  localparam logic [4:0] OP_SRA     = 5'b00111;
  localparam logic [4:0] OP_OR      = 5'b01000;
  localparam logic [4:0] OP_AND     = 5'b01001;
  localparam logic [4:0] OP_BEQ     = 5'b01010;
  localparam logic [4:0] OP_PASSB   = 5'b01011;
  localparam logic [4:0] OP_BNE     = 5'b01100;
  localparam logic [4:0] OP_BLT     = 5'b01101;
  localparam logic [4:0] OP_BGE     = 5'b01110;
  localparam logic [4:0] OP_BLTU    = 5'b01111;
  localparam logic [4:0] OP_MD      = 5'b10000;
  localparam logic [4:0] OP_BGEU    = 5'b10001;
  localparam logic [4:0] OP_ILLEGAL = 5'b11111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, next_state;
  logic              m_req, start, last;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mag;
  logic              neg_a, neg_b;
  logic [1:0]        f3;
  logic [CW-1:0]     count;

  logic              sign_a_en, sign_b_en, neg_a_in, neg_b_in;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_result;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_signed;
  logic [XLEN:0]     div_rem;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo_signed, rem_signed, mul_res, div_res, final_result;

  assign m_req = (ALUOp == 2'b10) && IsRType && (Funct7 == 7'b0000001);
  // A new M-op is only taken from IDLE, so the instruction still held during DONE cannot retrigger.
  assign start = (state == IDLE) && valid_i && m_req && ENABLE_M;
  assign last  = (count == CW'(XLEN - 1));

  assign stall_o    = start || (state == MUL) || (state == DIV);
  assign busy_o     = (state != IDLE);
  assign md_valid_o = (state == DONE);

  // Zero-latency ALU operation decode
  always_comb begin
    Operation = OP_ILLEGAL;
    case (ALUOp)
      2'b00: Operation = OP_ADD;
      2'b11: Operation = OP_PASSB;
      2'b01: begin
        case (Funct3)
          3'b000:  Operation = OP_BEQ;
          3'b001:  Operation = OP_BNE;
          3'b100:  Operation = OP_BLT;
          3'b101:  Operation = OP_BGE;
          3'b110:  Operation = OP_BLTU;
          3'b111:  Operation = OP_BGEU;
          default: Operation = OP_ILLEGAL;
        endcase
      end
      default: begin
        if (m_req) begin
          Operation = ENABLE_M ? OP_MD : OP_ILLEGAL;
        end else begin
          case (Funct3)
            3'b000:  Operation = (IsRType && Funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
            3'b001:  Operation = OP_SLL;
            3'b010:  Operation = OP_SLT;
            3'b011:  Operation = OP_SLTU;
            3'b100:  Operation = OP_XOR;
            3'b101:  Operation = (Funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
            3'b110:  Operation = OP_OR;
            default: Operation = OP_AND;
          endcase
        end
      end
    endcase
  end

  // Operand signedness by Funct3. MUL (000) is treated as signed x signed.
  // That is harmless because only the low half is kept.
  assign sign_a_en = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
  assign sign_b_en = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
  assign neg_a_in  = sign_a_en & rs1_i[XLEN-1];
  assign neg_b_in  = sign_b_en & rs2_i[XLEN-1];
  assign mag_a_in  = neg_a_in ? -rs1_i : rs1_i;
  assign mag_b_in  = neg_b_in ? -rs2_i : rs2_i;

  assign div_zero       = (rs2_i == '0);
  assign div_ovf        = ~Funct3[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
  assign special        = Funct3[2] && (div_zero || div_ovf);
  assign special_result = div_zero ? (Funct3[1] ? rs1_i : '1) : (Funct3[1] ? '0 : rs1_i);

  // Multiply step: acc holds {partial high, remaining multiplier bits}; add A when the LSB is set, shift right.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag};
  assign mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  // The difference needs only XLEN bits because the remainder is always below the divisor after restoring.
  assign div_rem  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge   = (div_rem >= {1'b0, mag});
  assign div_diff = div_rem[XLEN-1:0] - mag;
  assign div_next = {(div_ge ? div_diff : div_rem[XLEN-1:0]), acc[XLEN-2:0], div_ge};

  assign prod_signed  = (neg_a ^ neg_b) ? -mul_next : mul_next;
  assign mul_res      = (f3 == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
  assign quo_signed   = (neg_a ^ neg_b) ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
  assign rem_signed   = neg_a ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
  assign div_res      = f3[1] ? rem_signed : quo_signed;
  assign final_result = (state == MUL) ? mul_res : div_res;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; special-case divides skip straight to DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!Funct3[2])   next_state = MUL;
          else if (special) next_state = DONE;
          else              next_state = DIV;
        end
      end
      MUL:     if (last) next_state = DONE;
      DIV:     if (last) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register.
  // The result is captured on the edge into DONE and then held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      mag         <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      f3          <= '0;
      count       <= '0;
      md_result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= {{XLEN{1'b0}}, (Funct3[2] ? mag_a_in : mag_b_in)};
            mag   <= Funct3[2] ? mag_b_in : mag_a_in;
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            f3    <= Funct3[1:0];
            count <= '0;
            if (special) md_result_o <= special_result;
          end
        end
        MUL, DIV: begin
          acc   <= (state == MUL) ? mul_next : div_next;
          count <= count + CW'(1);
          if (last) md_result_o <= final_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_controller.sv
// tb_alu_md_controller
//   Self-checking bench for alu_md_controller. It uses three instances:
//   XLEN=32 with M enabled, XLEN=32 with M disabled, and XLEN=16 with M enabled.
//   Results are compared against a behavioural model built on 64-bit arithmetic.
module tb_alu_md_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, valid16;
  logic [1:0]  ALUOp;
  logic        IsRType;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] rs1_i, rs2_i;
  logic [15:0] rs1s, rs2s;

  logic [4:0]  op32, opnm, op16;
  logic        stall32, busy32, mdv32;
  logic        stallnm, busynm, mdvnm;
  logic        stall16, busy16, mdv16;
  logic [31:0] res32, resnm;
  logic [15:0] res16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_md_controller #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ALUOp(ALUOp), .IsRType(IsRType),
    .Funct7(Funct7), .Funct3(Funct3), .rs1_i(rs1_i), .rs2_i(rs2_i), .Operation(op32),
    .stall_o(stall32), .busy_o(busy32), .md_valid_o(mdv32), .md_result_o(res32));

  alu_md_controller #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ALUOp(ALUOp), .IsRType(IsRType),
    .Funct7(Funct7), .Funct3(Funct3), .rs1_i(rs1_i), .rs2_i(rs2_i), .Operation(opnm),
    .stall_o(stallnm), .busy_o(busynm), .md_valid_o(mdvnm), .md_result_o(resnm));

  alu_md_controller #(.XLEN(16), .ENABLE_M(1'b1)) dut16 (
    .clk(clk), .reset(reset), .valid_i(valid16), .ALUOp(ALUOp), .IsRType(IsRType),
    .Funct7(Funct7), .Funct3(Funct3), .rs1_i(rs1s), .rs2_i(rs2s), .Operation(op16),
    .stall_o(stall16), .busy_o(busy16), .md_valid_o(mdv16), .md_result_o(res16));

  // Reference decode, written as a direct table of the instruction classes
  function automatic logic [4:0] model_op(input logic [1:0] aop, input logic rt,
                                          input logic [6:0] f7, input logic [2:0] f3, input bit en_m);
    if (aop == 2'b00) return 5'b00000;
    if (aop == 2'b11) return 5'b01011;
    if (aop == 2'b01) begin
      case (f3)
        3'd0: return 5'b01010;
        3'd1: return 5'b01100;
        3'd4: return 5'b01101;
        3'd5: return 5'b01110;
        3'd6: return 5'b01111;
        3'd7: return 5'b10001;
        default: return 5'b11111;
      endcase
    end
    if (rt && f7 == 7'h01) return en_m ? 5'b10000 : 5'b11111;
    case (f3)
      3'd0: return (rt && f7 == 7'h20) ? 5'b00001 : 5'b00000;
      3'd1: return 5'b00010;
      3'd2: return 5'b00011;
      3'd3: return 5'b00100;
      3'd4: return 5'b00101;
      3'd5: return (f7 == 7'h20) ? 5'b00111 : 5'b00110;
      3'd6: return 5'b01000;
      default: return 5'b01001;
    endcase
  endfunction

  // Reference RV32M result using wide arithmetic
  function automatic logic [31:0] model_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = '1;
        else r = a / b;
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic logic [15:0] model_mul16(input logic [1:0] f3, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {48'b0, a};
    ub = {48'b0, b};
    case (f3)
      2'd0, 2'd1: p = sa * sb;
      2'd2:       p = sa * ub;
      default:    p = ua * ub;
    endcase
    return (f3 == 2'd0) ? p[15:0] : p[31:16];
  endfunction

  // Cycles from request to valid pulse, counting the request cycle as 1
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 2;
    return 34;
  endfunction

  // Issues one M-op on the 32-bit instances and measures latency, stall cycles and result.
  // Operands and Funct3 are scrambled while busy.
  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int stalls, output logic [31:0] res,
                           output bit nm_stall, output bit busy_after);
    int cyc;
    bit got;
    @(posedge clk); #1;
    valid_i = 1'b1; ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'h01;
    Funct3 = f3; rs1_i = a; rs2_i = b;
    lat = 0; stalls = 0; res = '0; nm_stall = 1'b0; cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      cyc++;
      @(negedge clk);
      if (stallnm) nm_stall = 1'b1;
      if (stall32) stalls++;
      if (mdv32) begin got = 1'b1; lat = cyc; res = res32; end
      @(posedge clk); #1;
      if (!got) begin rs1_i = $urandom; rs2_i = $urandom; Funct3 = 3'($urandom); end
    end
    valid_i = 1'b0;
    @(negedge clk);
    busy_after = busy32;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (busy32 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy32); end
    tests++; if (mdv32 !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", mdv32); end
    tests++; if (res32 !== 32'h0) begin fails++; $display("[TB] FAIL reset_result: got %h expected 0", res32); end
    tests++; if (stall32 !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall32); end
    tests++; if (res16 !== 16'h0) begin fails++; $display("[TB] FAIL reset_result16: got %h expected 0", res16); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (busy32 !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_busy: got %0b expected 0", busy32); end
  endtask

  task automatic test_decode;
    logic [4:0] fixed_exp [4];
    logic [4:0] e;
    fixed_exp[0] = 5'b00000; fixed_exp[1] = 5'b00001; fixed_exp[2] = 5'b10001; fixed_exp[3] = 5'b01011;
    valid_i = 1'b0;
    for (int i = 0; i < 160; i++) begin
      case (i)
        0: begin ALUOp = 2'b10; IsRType = 1'b0; Funct7 = 7'h20; Funct3 = 3'b000; end
        1: begin ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'h20; Funct3 = 3'b000; end
        2: begin ALUOp = 2'b01; IsRType = 1'b0; Funct7 = 7'h00; Funct3 = 3'b111; end
        3: begin ALUOp = 2'b11; IsRType = 1'b0; Funct7 = 7'h00; Funct3 = 3'b000; end
        default: begin
          ALUOp = 2'($urandom_range(0, 3));
          IsRType = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 3))
            0: Funct7 = 7'h00;
            1: Funct7 = 7'h20;
            2: Funct7 = 7'h01;
            default: Funct7 = 7'($urandom);
          endcase
          Funct3 = 3'($urandom);
        end
      endcase
      #1;
      if (i < 4) begin
        tests++;
        if (op32 !== fixed_exp[i]) begin fails++; $display("[TB] FAIL decode_fixed%0d: got %b expected %b", i, op32, fixed_exp[i]); end
      end
      e = model_op(ALUOp, IsRType, Funct7, Funct3, 1'b1);
      tests++;
      if (op32 !== e) begin fails++; $display("[TB] FAIL decode: aluop=%b rt=%b f7=%h f3=%b got %b expected %b", ALUOp, IsRType, Funct7, Funct3, op32, e); end
      e = model_op(ALUOp, IsRType, Funct7, Funct3, 1'b0);
      tests++;
      if (opnm !== e) begin fails++; $display("[TB] FAIL decode_nom: aluop=%b rt=%b f7=%h f3=%b got %b expected %b", ALUOp, IsRType, Funct7, Funct3, opnm, e); end
      tests++;
      if (stall32 !== 1'b0) begin fails++; $display("[TB] FAIL decode_stall: got %0b expected 0", stall32); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_disable_m;
    int lat, st;
    logic [31:0] r;
    bit nms, ba;
    valid_i = 1'b0; ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'h01; Funct3 = 3'b000;
    #1;
    tests++; if (opnm !== 5'b11111) begin fails++; $display("[TB] FAIL nom_op: got %b expected 11111", opnm); end
    tests++; if (op32 !== 5'b10000) begin fails++; $display("[TB] FAIL m_op: got %b expected 10000", op32); end
    drive_mop(3'b000, 32'd6, 32'd7, lat, st, r, nms, ba);
    tests++; if (nms !== 1'b0) begin fails++; $display("[TB] FAIL nom_stall: got %0b expected 0", nms); end
    tests++; if (busynm !== 1'b0) begin fails++; $display("[TB] FAIL nom_busy: got %0b expected 0", busynm); end
    tests++; if (r !== 32'd42) begin fails++; $display("[TB] FAIL nom_side_mul: got %h expected %h", r, 32'd42); end
  endtask

  task automatic test_md_directed;
    logic [2:0]  tf3 [9];
    logic [31:0] ta [9], tb [9], tr [9];
    int lat, st, el;
    logic [31:0] r;
    bit nms, ba;
    tf3[0]=3'd3; ta[0]=32'hFFFFFFFF; tb[0]=32'hFFFFFFFF; tr[0]=32'hFFFFFFFE;
    tf3[1]=3'd0; ta[1]=32'hFFFFFFFF; tb[1]=32'hFFFFFFFF; tr[1]=32'h00000001;
    tf3[2]=3'd4; ta[2]=32'hFFFFFFF9; tb[2]=32'd2;        tr[2]=32'hFFFFFFFD;
    tf3[3]=3'd6; ta[3]=32'hFFFFFFF9; tb[3]=32'd2;        tr[3]=32'hFFFFFFFF;
    tf3[4]=3'd5; ta[4]=32'hFFFFFFF9; tb[4]=32'd2;        tr[4]=32'h7FFFFFFC;
    tf3[5]=3'd4; ta[5]=32'd5;        tb[5]=32'd0;        tr[5]=32'hFFFFFFFF;
    tf3[6]=3'd7; ta[6]=32'd5;        tb[6]=32'd0;        tr[6]=32'd5;
    tf3[7]=3'd4; ta[7]=32'h80000000; tb[7]=32'hFFFFFFFF; tr[7]=32'h80000000;
    tf3[8]=3'd6; ta[8]=32'h80000000; tb[8]=32'hFFFFFFFF; tr[8]=32'h0;
    for (int i = 0; i < 9; i++) begin
      drive_mop(tf3[i], ta[i], tb[i], lat, st, r, nms, ba);
      el = exp_lat(tf3[i], ta[i], tb[i]);
      tests++; if (r !== tr[i]) begin fails++; $display("[TB] FAIL md_dir%0d_result: got %h expected %h", i, r, tr[i]); end
      tests++; if (lat != el) begin fails++; $display("[TB] FAIL md_dir%0d_latency: got %0d expected %0d", i, lat, el); end
      tests++; if (st != el - 1) begin fails++; $display("[TB] FAIL md_dir%0d_stalls: got %0d expected %0d", i, st, el - 1); end
      tests++; if (ba !== 1'b0) begin fails++; $display("[TB] FAIL md_dir%0d_retrigger: busy got %0b expected 0", i, ba); end
      repeat (3) @(negedge clk);
      tests++; if (res32 !== tr[i]) begin fails++; $display("[TB] FAIL md_dir%0d_hold: got %h expected %h", i, res32, tr[i]); end
    end
  endtask

  task automatic test_md_random;
    logic [2:0] f3;
    logic [31:0] a, b, er, r;
    int lat, st, el;
    bit nms, ba;
    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        default: b = 32'($urandom);
      endcase
      er = model_md(f3, a, b);
      el = exp_lat(f3, a, b);
      drive_mop(f3, a, b, lat, st, r, nms, ba);
      tests++; if (r !== er) begin fails++; $display("[TB] FAIL md_rand f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, r, er); end
      tests++; if (lat != el) begin fails++; $display("[TB] FAIL md_rand_latency f3=%0d: got %0d expected %0d", f3, lat, el); end
      tests++; if (ba !== 1'b0) begin fails++; $display("[TB] FAIL md_rand_retrigger: busy got %0b expected 0", ba); end
    end
  endtask

  // Second M-op presented in the IDLE cycle right after DONE, valid held high throughout
  task automatic test_back_to_back;
    int cyc;
    bit got;
    logic [31:0] r1, r2;
    @(posedge clk); #1;
    valid_i = 1'b1; ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'h01;
    Funct3 = 3'd1; rs1_i = 32'hFFFFFFF0; rs2_i = 32'h00000010;
    cyc = 0; got = 1'b0; r1 = '0;
    while (!got && cyc < 100) begin
      cyc++;
      @(negedge clk);
      if (mdv32) begin got = 1'b1; r1 = res32; end
      @(posedge clk); #1;
    end
    tests++; if (r1 !== model_md(3'd1, 32'hFFFFFFF0, 32'h10)) begin fails++; $display("[TB] FAIL b2b_first: got %h expected %h", r1, model_md(3'd1, 32'hFFFFFFF0, 32'h10)); end
    Funct3 = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd7;
    @(negedge clk);
    tests++; if (busy32 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_idle_gap: busy got %0b expected 0", busy32); end
    tests++; if (stall32 !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept_stall: got %0b expected 1", stall32); end
    cyc = 1; got = 1'b0; r2 = '0;
    @(posedge clk); #1;
    while (!got && cyc < 100) begin
      cyc++;
      @(negedge clk);
      if (mdv32) begin got = 1'b1; r2 = res32; end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    tests++; if (r2 !== 32'd142) begin fails++; $display("[TB] FAIL b2b_second: got %h expected %h", r2, 32'd142); end
    tests++; if (cyc != 34) begin fails++; $display("[TB] FAIL b2b_second_latency: got %0d expected 34", cyc); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    int lat, st;
    logic [31:0] r;
    bit nms, ba;
    @(posedge clk); #1;
    valid_i = 1'b1; ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'h01;
    Funct3 = 3'd3; rs1_i = 32'hFFFFFFFF; rs2_i = 32'hFFFFFFFF;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1; valid_i = 1'b0;
    #1;
    tests++; if (busy32 !== 1'b0) begin fails++; $display("[TB] FAIL midreset_busy: got %0b expected 0", busy32); end
    tests++; if (stall32 !== 1'b0) begin fails++; $display("[TB] FAIL midreset_stall: got %0b expected 0", stall32); end
    tests++; if (mdv32 !== 1'b0) begin fails++; $display("[TB] FAIL midreset_valid: got %0b expected 0", mdv32); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mdv32) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL midreset_pulse: got %0b expected 0", seen); end
    drive_mop(3'd0, 32'd3, 32'd5, lat, st, r, nms, ba);
    tests++; if (r !== 32'd15) begin fails++; $display("[TB] FAIL midreset_next_result: got %h expected %h", r, 32'd15); end
    tests++; if (lat != 34) begin fails++; $display("[TB] FAIL midreset_next_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_xlen16;
    int cyc, st;
    bit got;
    logic [1:0] f3;
    logic [15:0] a, b, er, r;
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin f3 = 2'd1; a = 16'h8000; b = 16'h8000; end
      else begin f3 = 2'($urandom); a = 16'($urandom); b = 16'($urandom); end
      er = (i == 0) ? 16'h4000 : model_mul16(f3, a, b);
      @(posedge clk); #1;
      valid16 = 1'b1; ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'h01;
      Funct3 = {1'b0, f3}; rs1s = a; rs2s = b;
      cyc = 0; st = 0; got = 1'b0; r = '0;
      while (!got && cyc < 60) begin
        cyc++;
        @(negedge clk);
        if (stall16) st++;
        if (mdv16) begin got = 1'b1; r = res16; end
        @(posedge clk); #1;
        if (!got) begin rs1s = 16'($urandom); rs2s = 16'($urandom); end
      end
      valid16 = 1'b0;
      tests++; if (r !== er) begin fails++; $display("[TB] FAIL x16_result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, r, er); end
      tests++; if (cyc != 18) begin fails++; $display("[TB] FAIL x16_latency: got %0d expected 18", cyc); end
      tests++; if (st != 17) begin fails++; $display("[TB] FAIL x16_stalls: got %0d expected 17", st); end
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; valid16 = 1'b0; ALUOp = 2'b00; IsRType = 1'b0;
    Funct7 = 7'h00; Funct3 = 3'b000; rs1_i = '0; rs2_i = '0; rs1s = '0; rs2s = '0;
    test_reset;
    test_decode;
    test_disable_m;
    test_md_directed;
    test_md_random;
    test_back_to_back;
    test_reset_mid;
    test_xlen16;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
